// File: rtl/alu_dispatch.sv
// alu_dispatch
//   Issues operations to four external ALU lanes and returns their results
//   strictly in acceptance order. Slot i is permanently bound to lane i.
//   Operations are accepted into slot[issue_ptr] and retired from
//   slot[ret_ptr]. Both pointers are 2-bit and wrap 3->0, so the slots form a
//   ring. A slot drives its lane for two cycles, captures the lane result and
//   flags, then holds them until the result handshake retires it.
//
// Ports
//   clk, rst_n                      clock; synchronous active-low reset
//   op_valid/op_ready               operation request handshake
//   op_func/op_a/op_b/op_tag        operation payload (op_func uses the
//                                   opcodes.v encoding: DIV = 6'h03, MOD = 6'h04)
//   en_alu[i]                       lane i enable, high while slot i drives
//   alu_func/alu_in1/alu_in2        lane i at [6i+5:6i] / [64i+63:64i]
//   alu_result/alu_zero/alu_overflow/alu_compare/alu_parity_odd
//                                   per-lane ALU returns
//   res_valid/res_ready             result handshake
//   res_data/res_tag/res_flags/res_err
//                                   oldest result; flags are
//                                   {overflow, zero, compare, parity_odd}
//
// Configuration
//   ALU_DIVZERO_TRAP_EN  when defined, DIV/MOD with op_b == 0 bypasses the
//                        lane and completes one cycle after acceptance with
//                        res_err = 1, res_data = 0, res_flags = 0. When
//                        undefined such ops dispatch normally and res_err
//                        is constant 0.

module alu_dispatch (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [5:0]   op_func,
    input  logic [63:0]  op_a,
    input  logic [63:0]  op_b,
    input  logic [3:0]   op_tag,
    output logic [3:0]   en_alu,
    output logic [23:0]  alu_func,
    output logic [255:0] alu_in1,
    output logic [255:0] alu_in2,
    input  logic [255:0] alu_result,
    input  logic [3:0]   alu_zero,
    input  logic [3:0]   alu_overflow,
    input  logic [3:0]   alu_compare,
    input  logic [3:0]   alu_parity_odd,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [63:0]  res_data,
    output logic [3:0]   res_tag,
    output logic [3:0]   res_flags,
    output logic         res_err
);

    localparam int unsigned NLANE = 4;

    // S_TRAP is only reachable with ALU_DIVZERO_TRAP_EN: a non-IDLE,
    // non-driving holding state for the single cycle before DONE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2,
        S_TRAP  = 2'd3
    } slot_e;

    slot_e       state_q  [NLANE];
    slot_e       state_d  [NLANE];
    logic        settle_q [NLANE];
    logic        settle_d [NLANE];
    logic [5:0]  func_q   [NLANE];
    logic [5:0]  func_d   [NLANE];
    logic [63:0] in1_q    [NLANE];
    logic [63:0] in1_d    [NLANE];
    logic [63:0] in2_q    [NLANE];
    logic [63:0] in2_d    [NLANE];
    logic [63:0] data_q   [NLANE];
    logic [63:0] data_d   [NLANE];
    logic [3:0]  tag_q    [NLANE];
    logic [3:0]  tag_d    [NLANE];
    logic [3:0]  flags_q  [NLANE];
    logic [3:0]  flags_d  [NLANE];
    logic [1:0]  issue_ptr_q, issue_ptr_d;
    logic [1:0]  ret_ptr_q,   ret_ptr_d;
    logic        accept;
    logic        retire;

`ifdef ALU_DIVZERO_TRAP_EN
    localparam logic [5:0] OP_DIV = 6'h03;
    localparam logic [5:0] OP_MOD = 6'h04;

    logic err_q [NLANE];
    logic err_d [NLANE];
    logic div_by_zero;

    assign div_by_zero = ((op_func == OP_DIV) || (op_func == OP_MOD)) && (op_b == '0);
    assign res_err     = err_q[ret_ptr_q];
`else
    assign res_err     = 1'b0;
`endif

    // Handshake outputs depend on registered state only, so a slot freed
    // at an edge becomes acceptable no earlier than the following cycle.
    assign op_ready  = (state_q[issue_ptr_q] == S_IDLE);
    assign res_valid = (state_q[ret_ptr_q] == S_DONE);
    assign accept    = op_valid && op_ready;
    assign retire    = res_valid && res_ready;

    assign res_data  = data_q[ret_ptr_q];
    assign res_tag   = tag_q[ret_ptr_q];
    assign res_flags = flags_q[ret_ptr_q];

    always_comb begin
        en_alu   = '0;
        alu_func = '0;
        alu_in1  = '0;
        alu_in2  = '0;
        for (int unsigned i = 0; i < NLANE; i++) begin
            en_alu[i]            = (state_q[i] == S_DRIVE);
            alu_func[6*i +: 6]   = func_q[i];
            alu_in1[64*i +: 64]  = in1_q[i];
            alu_in2[64*i +: 64]  = in2_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        func_d      = func_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        data_d      = data_q;
        tag_d       = tag_q;
        flags_d     = flags_q;
        issue_ptr_d = issue_ptr_q;
        ret_ptr_d   = ret_ptr_q;
`ifdef ALU_DIVZERO_TRAP_EN
        err_d       = err_q;
`endif

        // Per-slot progress; these never touch IDLE or DONE slots, so they
        // cannot collide with the accept/retire updates below.
        for (int unsigned i = 0; i < NLANE; i++) begin
            case (state_q[i])
                S_DRIVE: begin
                    if (settle_q[i]) begin
                        state_d[i] = S_DONE;
                        data_d[i]  = alu_result[64*i +: 64];
                        flags_d[i] = {alu_overflow[i], alu_zero[i],
                                      alu_compare[i], alu_parity_odd[i]};
`ifdef ALU_DIVZERO_TRAP_EN
                        err_d[i]   = 1'b0;
`endif
                    end else begin
                        settle_d[i] = 1'b1;
                    end
                end
`ifdef ALU_DIVZERO_TRAP_EN
                S_TRAP: begin
                    state_d[i] = S_DONE;
                    data_d[i]  = '0;
                    flags_d[i] = '0;
                    err_d[i]   = 1'b1;
                end
`endif
                default: ;
            endcase
        end

        if (retire) begin
            state_d[ret_ptr_q] = S_IDLE;
            ret_ptr_d          = ret_ptr_q + 2'd1;
        end

        if (accept) begin
            tag_d[issue_ptr_q] = op_tag;
            issue_ptr_d        = issue_ptr_q + 2'd1;
`ifdef ALU_DIVZERO_TRAP_EN
            if (div_by_zero) begin
                // Lane is left untouched so it keeps its last operands.
                state_d[issue_ptr_q] = S_TRAP;
            end else begin
                state_d[issue_ptr_q]  = S_DRIVE;
                settle_d[issue_ptr_q] = 1'b0;
                func_d[issue_ptr_q]   = op_func;
                in1_d[issue_ptr_q]    = op_a;
                in2_d[issue_ptr_q]    = op_b;
            end
`else
            state_d[issue_ptr_q]  = S_DRIVE;
            settle_d[issue_ptr_q] = 1'b0;
            func_d[issue_ptr_q]   = op_func;
            in1_d[issue_ptr_q]    = op_a;
            in2_d[issue_ptr_q]    = op_b;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NLANE; i++) begin
                state_q[i]  <= S_IDLE;
                settle_q[i] <= 1'b0;
                func_q[i]   <= '0;
                in1_q[i]    <= '0;
                in2_q[i]    <= '0;
                data_q[i]   <= '0;
                tag_q[i]    <= '0;
                flags_q[i]  <= '0;
`ifdef ALU_DIVZERO_TRAP_EN
                err_q[i]    <= 1'b0;
`endif
            end
            issue_ptr_q <= '0;
            ret_ptr_q   <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            func_q      <= func_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            flags_q     <= flags_d;
`ifdef ALU_DIVZERO_TRAP_EN
            err_q       <= err_d;
`endif
            issue_ptr_q <= issue_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a behavioural ALU stands in for the four lanes,
// and an in-order queue of expected results predicts the handshakes,
// lane enables and returned values.

module tb_alu_dispatch;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_INC = 6'h02;
    localparam logic [5:0] OP_DIV = 6'h03;
    localparam logic [5:0] OP_MOD = 6'h04;
    localparam logic [5:0] OP_AND = 6'h05;
    localparam logic [5:0] OP_XOR = 6'h06;
    localparam logic [5:0] OP_CMP = 6'h07;

`ifdef ALU_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    logic [5:0]   op_func;
    logic [63:0]  op_a;
    logic [63:0]  op_b;
    logic [3:0]   op_tag;
    logic [3:0]   en_alu;
    logic [23:0]  alu_func;
    logic [255:0] alu_in1;
    logic [255:0] alu_in2;
    logic [255:0] alu_result;
    logic [3:0]   alu_zero;
    logic [3:0]   alu_overflow;
    logic [3:0]   alu_compare;
    logic [3:0]   alu_parity_odd;
    logic         res_valid;
    logic         res_ready;
    logic [63:0]  res_data;
    logic [3:0]   res_tag;
    logic [3:0]   res_flags;
    logic         res_err;

    always #5 clk = ~clk;

    alu_dispatch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_func        (op_func),
        .op_a           (op_a),
        .op_b           (op_b),
        .op_tag         (op_tag),
        .en_alu         (en_alu),
        .alu_func       (alu_func),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .alu_compare    (alu_compare),
        .alu_parity_odd (alu_parity_odd),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_tag        (res_tag),
        .res_flags      (res_flags),
        .res_err        (res_err)
    );

    // Behavioural ALU: returns {overflow, zero, compare, parity_odd, data}.
    function automatic logic [67:0] alu_ref(input logic [5:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [64:0] w;
        logic [63:0] d;
        logic        ov;
        logic        cmp;
        w = '0; d = '0; ov = 1'b0; cmp = 1'b0;
        case (f)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; d = w[63:0]; ov = w[64]; end
            OP_SUB: begin d = a - b; ov = (a < b); end
            OP_INC: begin w = {1'b0, a} + 65'd1; d = w[63:0]; ov = w[64]; end
            OP_DIV: d = (b == 64'd0) ? '1 : a / b;
            OP_MOD: d = (b == 64'd0) ? a : a % b;
            OP_AND: d = a & b;
            OP_XOR: d = a ^ b;
            OP_CMP: begin d = a - b; cmp = (a < b); end
            default: d = '0;
        endcase
        return {ov, (d == 64'd0), cmp, ^d, d};
    endfunction

    always_comb begin
        logic [67:0] r;
        alu_result = '0; alu_zero = '0; alu_overflow = '0; alu_compare = '0; alu_parity_odd = '0;
        for (int i = 0; i < 4; i++) begin
            r = alu_ref(alu_func[6*i +: 6], alu_in1[64*i +: 64], alu_in2[64*i +: 64]);
            alu_result[64*i +: 64] = r[63:0];
            alu_overflow[i]        = r[67];
            alu_zero[i]            = r[66];
            alu_compare[i]         = r[65];
            alu_parity_odd[i]      = r[64];
        end
    end

    // Reference model: in-order queue of accepted operations.
    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        logic [3:0]  flags;
        logic        err;
        int          ready;   // cycle from which the result is visible
        logic [1:0]  lane;
        bit          trap;
    } exp_t;

    exp_t       mq[$];
    int         cyc;
    logic [1:0] lane_ctr;
    int         n_retired;
    int         n_checks;
    int         n_pass;

    function automatic bit m_op_ready();
        return mq.size() < 4;
    endfunction

    function automatic bit m_res_valid();
        return (mq.size() > 0) && (cyc >= mq[0].ready);
    endfunction

    function automatic logic [3:0] m_en();
        logic [3:0] en = '0;
        foreach (mq[i]) if (!mq[i].trap && cyc < mq[i].ready) en[mq[i].lane] = 1'b1;
        return en;
    endfunction

    // Called just after a falling edge; drives one cycle, advances the model
    // at the rising edge and returns at the next falling edge.
    task automatic step(input bit v, input logic [5:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] t, input bit rr);
        bit          acc;
        bit          ret;
        exp_t        e;
        logic [67:0] r;
        op_valid = v; op_func = f; op_a = a; op_b = b; op_tag = t; res_ready = rr;
        acc = v && m_op_ready();
        ret = rr && m_res_valid();
        @(posedge clk);
        cyc++;
        if (ret) begin
            mq.delete(0);
            n_retired++;
        end
        if (acc) begin
            e.trap  = TRAP && (f == OP_DIV || f == OP_MOD) && (b == 64'd0);
            r       = alu_ref(f, a, b);
            e.tag   = t;
            e.data  = e.trap ? 64'd0 : r[63:0];
            e.flags = e.trap ? 4'd0 : r[67:64];
            e.err   = e.trap;
            e.ready = cyc + (e.trap ? 1 : 2);
            e.lane  = lane_ctr;
            lane_ctr++;
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rr);
        step(1'b0, OP_ADD, 64'd0, 64'd0, 4'd0, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; op_valid = 1'b0; op_func = '0; op_a = '0; op_b = '0;
        op_tag = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        lane_ctr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (op_ready !== 1'b1) $display("FAIL reset_op_ready: got %b want 1", op_ready); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
        n_checks++; if (en_alu !== 4'b0) $display("FAIL reset_en_alu: got %b want 0000", en_alu); else n_pass++;
        n_checks++; if ({alu_func, alu_in1, alu_in2} !== '0) $display("FAIL reset_lanes: got func=%h in1=%h in2=%h want 0", alu_func, alu_in1, alu_in2); else n_pass++;
        n_checks++; if ({res_data, res_tag, res_flags, res_err} !== '0) $display("FAIL reset_res: got data=%h tag=%h flags=%b err=%b want 0", res_data, res_tag, res_flags, res_err); else n_pass++;
    endtask

    task automatic test_add();
        do_reset();
        step(1'b1, OP_ADD, 64'd5, 64'd7, 4'd3, 1'b0);
        n_checks++; if ({en_alu, res_valid} !== {4'b0001, 1'b0}) $display("FAIL add_drive1: got en=%b v=%b want 0001 0", en_alu, res_valid); else n_pass++;
        idle(1'b0);
        n_checks++; if ({en_alu, res_valid} !== {4'b0001, 1'b0}) $display("FAIL add_drive2: got en=%b v=%b want 0001 0", en_alu, res_valid); else n_pass++;
        idle(1'b0);
        n_checks++; if ({en_alu, res_valid} !== {4'b0000, 1'b1}) $display("FAIL add_done: got en=%b v=%b want 0000 1", en_alu, res_valid); else n_pass++;
        n_checks++; if ({res_data, res_tag, res_flags, res_err} !== {64'd12, 4'd3, 4'b0000, 1'b0}) $display("FAIL add_result: got data=%0d tag=%0d flags=%b err=%b want 12 3 0000 0", res_data, res_tag, res_flags, res_err); else n_pass++;
        idle(1'b0);
        n_checks++; if ({res_valid, res_data, res_tag} !== {1'b1, 64'd12, 4'd3}) $display("FAIL add_hold: got v=%b data=%0d tag=%0d want 1 12 3", res_valid, res_data, res_tag); else n_pass++;
        n_checks++; if ({alu_func[5:0], alu_in1[63:0], alu_in2[63:0]} !== {OP_ADD, 64'd5, 64'd7}) $display("FAIL add_lane_keep: got func=%h in1=%0d in2=%0d want 0 5 7", alu_func[5:0], alu_in1[63:0], alu_in2[63:0]); else n_pass++;
        idle(1'b1);
        n_checks++; if ({res_valid, op_ready} !== 2'b01) $display("FAIL add_retire: got v=%b rdy=%b want 0 1", res_valid, op_ready); else n_pass++;
    endtask

    task automatic test_flags();
        step(1'b1, OP_SUB, 64'd1, 64'd1, 4'd5, 1'b0);
        idle(1'b0); idle(1'b0);
        n_checks++; if ({res_valid, res_data, res_tag, res_flags[2]} !== {1'b1, 64'd0, 4'd5, 1'b1}) $display("FAIL sub_zero: got v=%b data=%h tag=%0d zero=%b want 1 0 5 1", res_valid, res_data, res_tag, res_flags[2]); else n_pass++;
        idle(1'b1);
        step(1'b1, OP_INC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd6, 1'b0);
        idle(1'b0); idle(1'b0);
        n_checks++; if ({res_valid, res_tag, res_flags[3]} !== {1'b1, 4'd6, 1'b1}) $display("FAIL inc_overflow: got v=%b tag=%0d ovf=%b want 1 6 1", res_valid, res_tag, res_flags[3]); else n_pass++;
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (op_ready !== (i < 4)) $display("FAIL b2b_ready%0d: got %b want %b", i, op_ready, (i < 4)); else n_pass++;
            step(1'b1, OP_ADD, 64'(i), 64'(i + 1), 4'(i), 1'b0);
        end
        step(1'b1, OP_ADD, 64'd4, 64'd5, 4'd4, 1'b0);
        n_checks++; if ({op_ready, res_valid, en_alu, res_tag} !== {1'b0, 1'b1, 4'b0000, 4'd0}) $display("FAIL b2b_full: got rdy=%b v=%b en=%b tag=%0d want 0 1 0000 0", op_ready, res_valid, en_alu, res_tag); else n_pass++;
        step(1'b1, OP_ADD, 64'd4, 64'd5, 4'd4, 1'b1);
        n_checks++; if ({op_ready, res_tag} !== {1'b1, 4'd1}) $display("FAIL b2b_ret0: got rdy=%b tag=%0d want 1 1", op_ready, res_tag); else n_pass++;
        step(1'b1, OP_ADD, 64'd4, 64'd5, 4'd4, 1'b1);
        n_checks++; if ({en_alu, res_tag} !== {4'b0001, 4'd2}) $display("FAIL b2b_acc_ret: got en=%b tag=%0d want 0001 2", en_alu, res_tag); else n_pass++;
        idle(1'b1);
        n_checks++; if ({en_alu, res_tag} !== {4'b0001, 4'd3}) $display("FAIL b2b_ret2: got en=%b tag=%0d want 0001 3", en_alu, res_tag); else n_pass++;
        idle(1'b1);
        n_checks++; if ({res_valid, res_tag, res_data} !== {1'b1, 4'd4, 64'd9}) $display("FAIL b2b_fifth: got v=%b tag=%0d data=%0d want 1 4 9", res_valid, res_tag, res_data); else n_pass++;
        idle(1'b1);
        n_checks++; if (res_valid !== 1'b0) $display("FAIL b2b_empty: got v=%b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(1'b1, OP_XOR, 64'hA5, 64'h5A, 4'd1, 1'b0);
        step(1'b1, OP_ADD, 64'd2, 64'd3, 4'd2, 1'b0);
        step(1'b1, OP_SUB, 64'd9, 64'd4, 4'd3, 1'b0);
        n_checks++; if ({res_valid, en_alu} !== {1'b1, 4'b0110}) $display("FAIL mid_pre: got v=%b en=%b want 1 0110", res_valid, en_alu); else n_pass++;
        // Reset with accept and retire both requested on the same edge.
        rst_n = 1'b0; op_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        cyc++;
        mq.delete();
        lane_ctr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if ({en_alu, res_valid, op_ready} !== {4'b0000, 1'b0, 1'b1}) $display("FAIL mid_reset: got en=%b v=%b rdy=%b want 0000 0 1", en_alu, res_valid, op_ready); else n_pass++;
        n_checks++; if ({alu_func, alu_in1} !== '0) $display("FAIL mid_lanes: got func=%h in1=%h want 0", alu_func, alu_in1); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            n_checks++; if ({res_valid, op_ready, en_alu} !== {1'b0, 1'b1, 4'b0000}) $display("FAIL mid_after%0d: got v=%b rdy=%b en=%b want 0 1 0000", i, res_valid, op_ready, en_alu); else n_pass++;
        end
    endtask

    task automatic test_divzero();
        do_reset();
        step(1'b1, OP_DIV, 64'd9, 64'd0, 4'd7, 1'b0);
        if (TRAP) begin
            n_checks++; if ({en_alu, res_valid} !== {4'b0000, 1'b0}) $display("FAIL dz_trap1: got en=%b v=%b want 0000 0", en_alu, res_valid); else n_pass++;
            idle(1'b0);
            n_checks++; if ({en_alu, res_valid, res_err, res_data, res_flags, res_tag} !== {4'b0000, 1'b1, 1'b1, 64'd0, 4'd0, 4'd7}) $display("FAIL dz_trap2: got en=%b v=%b err=%b data=%h flags=%b tag=%0d want 0000 1 1 0 0000 7", en_alu, res_valid, res_err, res_data, res_flags, res_tag); else n_pass++;
        end else begin
            n_checks++; if ({en_alu, res_valid} !== {4'b0001, 1'b0}) $display("FAIL dz_drive1: got en=%b v=%b want 0001 0", en_alu, res_valid); else n_pass++;
            idle(1'b0);
            n_checks++; if ({en_alu, res_valid} !== {4'b0001, 1'b0}) $display("FAIL dz_drive2: got en=%b v=%b want 0001 0", en_alu, res_valid); else n_pass++;
            idle(1'b0);
            n_checks++; if ({res_valid, res_err, res_data, res_tag} !== {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7}) $display("FAIL dz_normal: got v=%b err=%b data=%h tag=%0d want 1 0 ffffffffffffffff 7", res_valid, res_err, res_data, res_tag); else n_pass++;
        end
        idle(1'b1);
        n_checks++; if (res_valid !== 1'b0) $display("FAIL dz_retire: got v=%b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_stream();
        int start;
        do_reset();
        start = n_retired;
        for (int i = 0; i < 64; i++) begin
            n_checks++; if (op_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i, op_ready); else n_pass++;
            if (m_res_valid()) begin
                n_checks++; if ({res_valid, res_tag, res_data, res_flags} !== {1'b1, mq[0].tag, mq[0].data, mq[0].flags}) $display("FAIL stream_res%0d: got v=%b tag=%0d data=%h flags=%b want 1 %0d %h %b", i, res_valid, res_tag, res_data, res_flags, mq[0].tag, mq[0].data, mq[0].flags); else n_pass++;
            end
            step(1'b1, 6'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 4'(i), 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            if (m_res_valid()) begin
                n_checks++; if ({res_valid, res_tag, res_data} !== {1'b1, mq[0].tag, mq[0].data}) $display("FAIL stream_drain%0d: got v=%b tag=%0d data=%h want 1 %0d %h", i, res_valid, res_tag, res_data, mq[0].tag, mq[0].data); else n_pass++;
            end
            idle(1'b1);
        end
        n_checks++; if ((n_retired - start) != 64 || res_valid !== 1'b0) $display("FAIL stream_count: got retired=%0d v=%b want 64 0", n_retired - start, res_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [63:0] b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            n_checks++; if (op_ready !== m_op_ready()) $display("FAIL rnd_ready%0d: got %b want %b", i, op_ready, m_op_ready()); else n_pass++;
            n_checks++; if (res_valid !== m_res_valid()) $display("FAIL rnd_valid%0d: got %b want %b", i, res_valid, m_res_valid()); else n_pass++;
            n_checks++; if (en_alu !== m_en()) $display("FAIL rnd_en%0d: got %b want %b", i, en_alu, m_en()); else n_pass++;
            if (m_res_valid()) begin
                n_checks++; if ({res_tag, res_data, res_flags, res_err} !== {mq[0].tag, mq[0].data, mq[0].flags, mq[0].err}) $display("FAIL rnd_res%0d: got tag=%0d data=%h flags=%b err=%b want %0d %h %b %b", i, res_tag, res_data, res_flags, res_err, mq[0].tag, mq[0].data, mq[0].flags, mq[0].err); else n_pass++;
            end
            f = 6'($urandom_range(0, 7));
            b = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            step($urandom_range(0, 3) != 0, f, {$urandom, $urandom}, b, 4'($urandom), $urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; lane_ctr = '0; n_retired = 0;
        rst_n = 1'b0; op_valid = 1'b0; op_func = '0; op_a = '0; op_b = '0;
        op_tag = '0; res_ready = 1'b0;
        test_reset();
        test_add();
        test_flags();
        test_back_to_back();
        test_reset_midflight();
        test_divzero();
        test_stream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
